// File: rtl/pkt_wr_ctrl_mq_if.sv
// Beat input, per-queue reader pointers, RAM write port and commit/status
// outputs of the multi-queue packet write controller.
interface pkt_wr_ctrl_mq_if #(
    parameter int DATA_W = 8,
    parameter int ID_W   = 3,
    parameter int NUM_Q  = 2,
    parameter int ADDR_W = 11
);
    localparam int QSEL_W  = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam int WDATA_W = DATA_W + ID_W + 2;

    logic [DATA_W-1:0]       in_data;
    logic                    in_sop;
    logic                    in_eop;
    logic [QSEL_W-1:0]       in_qos;
    logic [ID_W-1:0]         in_id;
    logic                    in_err;
    logic [NUM_Q*ADDR_W-1:0] rd_ptr;
    logic [NUM_Q-1:0]        ram_wen;
    logic [ADDR_W-1:0]       ram_waddr;
    logic [WDATA_W-1:0]      ram_wdata;
    logic [NUM_Q*ADDR_W-1:0] commit_waddr;
    logic                    pkt_done;
    logic                    pkt_drop;
    logic [1:0]              drop_cause;

    modport slave (
        input  in_data, in_sop, in_eop, in_qos, in_id, in_err, rd_ptr,
        output ram_wen, ram_waddr, ram_wdata, commit_waddr, pkt_done, pkt_drop, drop_cause
    );

    modport master (
        output in_data, in_sop, in_eop, in_qos, in_id, in_err, rd_ptr,
        input  ram_wen, ram_waddr, ram_wdata, commit_waddr, pkt_done, pkt_drop, drop_cause
    );
endinterface

// File: rtl/pkt_wr_ctrl_mq.sv
// Steers sop/eop framed packets into NUM_Q circular RAM queues by QoS class,
// with speculative write pointers that roll back to the committed pointer on a drop.
module pkt_wr_ctrl_mq #(
    parameter int DATA_W    = 8,
    parameter int ID_W      = 3,
    parameter int NUM_Q     = 2,
    parameter int ADDR_W    = 11,
    parameter int RAM_DEPTH = 1144,
    parameter int MAX_LEN   = 127
) (
    input  logic                clk,
    input  logic                rst_n,
    pkt_wr_ctrl_mq_if.slave     bus
);
    localparam int QSEL_W  = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam int WDATA_W = DATA_W + ID_W + 2;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
    localparam logic [1:0] CAUSE_LEN = 2'd0, CAUSE_FULL = 2'd1, CAUSE_SOP = 2'd2, CAUSE_ERR = 2'd3;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef enum logic [1:0] {IDLE, RCV, DISCARD} state_e;

    function automatic addr_t next_addr(input addr_t a);
        return (a == addr_t'(RAM_DEPTH - 1)) ? '0 : a + addr_t'(1);
    endfunction

    function automatic logic is_full(input addr_t cur, input addr_t rd);
        return next_addr(cur) == rd;
    endfunction

    function automatic logic [QSEL_W-1:0] map_qos(input logic [QSEL_W-1:0] q);
        return (int'(q) >= NUM_Q) ? QSEL_W'(NUM_Q - 1) : q;
    endfunction

    logic [DATA_W-1:0]       data_q;
    logic                    sop_q, eop_q, err_q;
    logic [QSEL_W-1:0]       qos_q;
    logic [ID_W-1:0]         id_q;
    addr_t                   rd_q [NUM_Q];

    state_e                  state_q, state_d;
    logic [QSEL_W-1:0]       pq_q, pq_d;
    logic [ID_W-1:0]         pid_q, pid_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    addr_t                   wr_cur_q [NUM_Q];
    addr_t                   wr_cur_d [NUM_Q];
    addr_t                   cmt_q [NUM_Q];
    addr_t                   cmt_d [NUM_Q];
    logic [NUM_Q-1:0]        wen_q, wen_d;
    addr_t                   waddr_q, waddr_d;
    logic [WDATA_W-1:0]      wdata_q, wdata_d;
    logic                    done_q, done_d, drop_q, drop_d;
    logic [1:0]              cause_q, cause_d;

    logic [NUM_Q*ADDR_W-1:0] cmt_flat;
    logic [NUM_Q*ADDR_W-1:0] cmt_out_q;
    logic                    done_out_q, drop_out_q;
    logic [1:0]              cause_out_q;

    logic                    start;
    logic [QSEL_W-1:0]       new_q;

    always_comb begin
        state_d  = state_q;
        pq_d     = pq_q;
        pid_d    = pid_q;
        cnt_d    = cnt_q;
        wr_cur_d = wr_cur_q;
        cmt_d    = cmt_q;
        wen_d    = '0;
        waddr_d  = '0;
        wdata_d  = '0;
        done_d   = 1'b0;
        drop_d   = 1'b0;
        cause_d  = CAUSE_LEN;
        start    = 1'b0;
        new_q    = map_qos(qos_q);

        if (state_q == RCV) begin
            drop_d = 1'b1;
            if (err_q)                                    cause_d = CAUSE_ERR;
            else if (sop_q)                               cause_d = CAUSE_SOP;
            else if (cnt_q >= MAX_CNT)                    cause_d = CAUSE_LEN;
            else if (is_full(wr_cur_q[pq_q], rd_q[pq_q])) cause_d = CAUSE_FULL;
            else                                          drop_d  = 1'b0;

            if (drop_d) begin
                wr_cur_d[pq_q] = cmt_q[pq_q];
                start          = sop_q && !err_q;
                state_d        = eop_q ? IDLE : DISCARD;
            end else begin
                wen_d[pq_q]    = 1'b1;
                waddr_d        = wr_cur_q[pq_q];
                wdata_d        = {1'b0, eop_q, pid_q, data_q};
                wr_cur_d[pq_q] = next_addr(wr_cur_q[pq_q]);
                cnt_d          = cnt_q + CNT_W'(1);
                if (eop_q) begin
                    cmt_d[pq_q] = next_addr(wr_cur_q[pq_q]);
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
        end else if (sop_q && err_q) begin
            drop_d  = 1'b1;
            cause_d = CAUSE_ERR;
            state_d = eop_q ? IDLE : DISCARD;
        end else if (sop_q) begin
            start = 1'b1;
        end else if (eop_q) begin
            state_d = IDLE;
        end

        // A new packet always starts at its queue's committed pointer, which is
        // also where an aborted packet on the same queue was rolled back to.
        if (start) begin
            pq_d  = new_q;
            pid_d = id_q;
            cnt_d = CNT_W'(1);
            if (is_full(cmt_q[new_q], rd_q[new_q])) begin
                if (!drop_d) cause_d = CAUSE_FULL;
                drop_d  = 1'b1;
                state_d = eop_q ? IDLE : DISCARD;
            end else begin
                wen_d[new_q]    = 1'b1;
                waddr_d         = cmt_q[new_q];
                wdata_d         = {1'b1, eop_q, id_q, data_q};
                wr_cur_d[new_q] = next_addr(cmt_q[new_q]);
                if (eop_q) begin
                    cmt_d[new_q] = next_addr(cmt_q[new_q]);
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = RCV;
                end
            end
        end
    end

    always_comb begin
        cmt_flat = '0;
        for (int q = 0; q < NUM_Q; q++) cmt_flat[q*ADDR_W +: ADDR_W] = cmt_q[q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
            qos_q       <= '0;
            id_q        <= '0;
            state_q     <= IDLE;
            pq_q        <= '0;
            pid_q       <= '0;
            cnt_q       <= '0;
            wen_q       <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            cause_q     <= '0;
            cmt_out_q   <= '0;
            done_out_q  <= 1'b0;
            drop_out_q  <= 1'b0;
            cause_out_q <= '0;
            for (int q = 0; q < NUM_Q; q++) begin
                rd_q[q]     <= '0;
                wr_cur_q[q] <= '0;
                cmt_q[q]    <= '0;
            end
        end else begin
            // input stage
            data_q <= bus.in_data;
            sop_q  <= bus.in_sop;
            eop_q  <= bus.in_eop;
            err_q  <= bus.in_err;
            qos_q  <= bus.in_qos;
            id_q   <= bus.in_id;
            for (int q = 0; q < NUM_Q; q++) rd_q[q] <= bus.rd_ptr[q*ADDR_W +: ADDR_W];
            // decision stage: RAM write, speculative and internal commit pointers
            state_q  <= state_d;
            pq_q     <= pq_d;
            pid_q    <= pid_d;
            cnt_q    <= cnt_d;
            wr_cur_q <= wr_cur_d;
            cmt_q    <= cmt_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
            cause_q  <= drop_d ? cause_d : 2'd0;
            // publish stage: commit pointers and status pulses
            cmt_out_q   <= cmt_flat;
            done_out_q  <= done_q;
            drop_out_q  <= drop_q;
            cause_out_q <= cause_q;
        end
    end

    assign bus.ram_wen      = wen_q;
    assign bus.ram_waddr    = waddr_q;
    assign bus.ram_wdata    = wdata_q;
    assign bus.commit_waddr = cmt_out_q;
    assign bus.pkt_done     = done_out_q;
    assign bus.pkt_drop     = drop_out_q;
    assign bus.drop_cause   = cause_out_q;
endmodule

// File: tb/tb_pkt_wr_ctrl_mq.sv
// Bench for pkt_wr_ctrl_mq: directed packet scenarios plus random beats,
// compared cycle by cycle against a packet-level reference model.
module tb_pkt_wr_ctrl_mq;
    localparam int DATA_W    = 8;
    localparam int ID_W      = 3;
    localparam int NUM_Q     = 2;
    localparam int ADDR_W    = 11;
    localparam int RAM_DEPTH = 1144;
    localparam int MAX_LEN   = 127;
    localparam int QSEL_W    = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam int WD_W      = DATA_W + ID_W + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pkt_wr_ctrl_mq_if #(.DATA_W(DATA_W), .ID_W(ID_W), .NUM_Q(NUM_Q), .ADDR_W(ADDR_W)) bus ();

    pkt_wr_ctrl_mq #(
        .DATA_W(DATA_W), .ID_W(ID_W), .NUM_Q(NUM_Q), .ADDR_W(ADDR_W),
        .RAM_DEPTH(RAM_DEPTH), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: committed pointer per queue plus the one open packet.
    int rdv   [NUM_Q];
    int m_cmt [NUM_Q];
    bit m_in_pkt;
    int m_q, m_id, m_cnt, m_cur;

    logic [NUM_Q-1:0] e_wen;
    int               e_addr;
    logic [WD_W-1:0]  e_data;
    bit               e_done, e_drop;
    int               e_cause;

    // Expectations in flight: write one cycle behind, commit/status two behind.
    logic [NUM_Q-1:0]        w1_wen;
    int                      w1_addr;
    logic [WD_W-1:0]         w1_data;
    logic [NUM_Q*ADDR_W-1:0] c1_cmt, c2_cmt;
    bit                      c1_done, c1_drop, c2_done, c2_drop;
    int                      c1_cause, c2_cause;

    task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int wrap_inc(input int a);
        return (a + 1) % RAM_DEPTH;
    endfunction

    function automatic void mdl_put(input int q, input int addr, input int fs, input int fe,
                                    input int idv, input int dv);
        e_wen  = NUM_Q'(1 << q);
        e_addr = addr;
        e_data = WD_W'((fs << (ID_W + DATA_W + 1)) | (fe << (ID_W + DATA_W)) | (idv << DATA_W) | dv);
    endfunction

    function automatic void mdl_drop(input int cause);
        if (!e_drop) begin
            e_drop  = 1'b1;
            e_cause = cause;
        end
        m_in_pkt = 1'b0;
    endfunction

    function automatic void mdl_open(input int qo, input int idv, input bit e, input int dv);
        int q;
        q     = (qo >= NUM_Q) ? NUM_Q - 1 : qo;
        m_q   = q;
        m_id  = idv;
        m_cnt = 1;
        m_cur = m_cmt[q];
        if (wrap_inc(m_cur) == rdv[q]) begin
            mdl_drop(1);
        end else begin
            mdl_put(q, m_cur, 1, int'(e), idv, dv);
            m_cur = wrap_inc(m_cur);
            if (e) begin
                m_cmt[q] = m_cur;
                e_done   = 1'b1;
                m_in_pkt = 1'b0;
            end else begin
                m_in_pkt = 1'b1;
            end
        end
    endfunction

    function automatic void mdl_beat(input bit s, input bit e, input bit er,
                                     input int qo, input int idv, input int dv);
        e_wen = '0; e_addr = 0; e_data = '0; e_done = 1'b0; e_drop = 1'b0; e_cause = 0;
        if (m_in_pkt) begin
            if (er) mdl_drop(3);
            else if (s) begin
                mdl_drop(2);
                mdl_open(qo, idv, e, dv);
            end
            else if (m_cnt + 1 > MAX_LEN) mdl_drop(0);
            else if (wrap_inc(m_cur) == rdv[m_q]) mdl_drop(1);
            else begin
                mdl_put(m_q, m_cur, 0, int'(e), m_id, dv);
                m_cur = wrap_inc(m_cur);
                m_cnt++;
                if (e) begin
                    m_cmt[m_q] = m_cur;
                    e_done     = 1'b1;
                    m_in_pkt   = 1'b0;
                end
            end
        end else if (s) begin
            if (er) mdl_drop(3);
            else    mdl_open(qo, idv, e, dv);
        end
    endfunction

    function automatic logic [NUM_Q*ADDR_W-1:0] pack_cmt();
        logic [NUM_Q*ADDR_W-1:0] v;
        v = '0;
        for (int q = 0; q < NUM_Q; q++) v[q*ADDR_W +: ADDR_W] = ADDR_W'(m_cmt[q]);
        return v;
    endfunction

    function automatic logic [NUM_Q*ADDR_W-1:0] pack_rd();
        logic [NUM_Q*ADDR_W-1:0] v;
        v = '0;
        for (int q = 0; q < NUM_Q; q++) v[q*ADDR_W +: ADDR_W] = ADDR_W'(rdv[q]);
        return v;
    endfunction

    task automatic cycle(input bit s, input bit e, input bit er, input int qo, input int idv, input int dv);
        int qm, im, dm;
        qm = qo % (1 << QSEL_W);
        im = idv % (1 << ID_W);
        dm = dv % (1 << DATA_W);
        bus.in_sop  = s;
        bus.in_eop  = e;
        bus.in_err  = er;
        bus.in_qos  = QSEL_W'(qm);
        bus.in_id   = ID_W'(im);
        bus.in_data = DATA_W'(dm);
        bus.rd_ptr  = pack_rd();
        @(posedge clk);
        mdl_beat(s, e, er, qm, im, dm);
        #1;
        check_vec("ram_wen", 64'(bus.ram_wen), 64'(w1_wen));
        if (w1_wen != '0) begin
            check_vec("ram_waddr", 64'(bus.ram_waddr), 64'(w1_addr));
            check_vec("ram_wdata", 64'(bus.ram_wdata), 64'(w1_data));
        end
        check_vec("commit_waddr", 64'(bus.commit_waddr), 64'(c2_cmt));
        check_vec("pkt_done", 64'(bus.pkt_done), 64'(c2_done));
        check_vec("pkt_drop", 64'(bus.pkt_drop), 64'(c2_drop));
        if (c2_drop) check_vec("drop_cause", 64'(bus.drop_cause), 64'(c2_cause));
        c2_cmt = c1_cmt; c2_done = c1_done; c2_drop = c1_drop; c2_cause = c1_cause;
        c1_cmt = pack_cmt(); c1_done = e_done; c1_drop = e_drop; c1_cause = e_cause;
        w1_wen = e_wen; w1_addr = e_addr; w1_data = e_data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic send_pkt(input int qo, input int idv, input int len, input int d0, input int dstep);
        for (int i = 0; i < len; i++)
            cycle(i == 0, i == len - 1, 1'b0, qo, idv, (d0 + i * dstep) % 256);
    endtask

    task automatic do_reset();
        bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.in_err = 1'b0;
        bus.in_qos = '0; bus.in_id = '0; bus.in_data = '0; bus.rd_ptr = '0;
        rst_n = 1'b0;
        #2;
        check_vec("rst_wen", 64'(bus.ram_wen), 64'd0);
        check_vec("rst_waddr", 64'(bus.ram_waddr), 64'd0);
        check_vec("rst_wdata", 64'(bus.ram_wdata), 64'd0);
        check_vec("rst_commit", 64'(bus.commit_waddr), 64'd0);
        check_vec("rst_done", 64'(bus.pkt_done), 64'd0);
        check_vec("rst_drop", 64'(bus.pkt_drop), 64'd0);
        check_vec("rst_cause", 64'(bus.drop_cause), 64'd0);
        for (int q = 0; q < NUM_Q; q++) begin
            m_cmt[q] = 0;
            rdv[q]   = 0;
        end
        m_in_pkt = 1'b0; m_q = 0; m_id = 0; m_cnt = 0; m_cur = 0;
        w1_wen = '0; w1_addr = 0; w1_data = '0;
        c1_cmt = '0; c1_done = 1'b0; c1_drop = 1'b0; c1_cause = 0;
        c2_cmt = '0; c2_done = 1'b0; c2_drop = 1'b0; c2_cause = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // single-beat packet on queue 1
        cycle(1'b1, 1'b1, 1'b0, 1, 5, 8'hA5);
        idle(1);
        check_vec("single_wen", 64'(bus.ram_wen), 64'b10);
        check_vec("single_waddr", 64'(bus.ram_waddr), 64'd0);
        check_vec("single_wdata", 64'(bus.ram_wdata), 64'h1DA5);
        idle(1);
        check_vec("single_commit1", 64'(bus.commit_waddr[ADDR_W +: ADDR_W]), 64'd1);
        check_vec("single_done", 64'(bus.pkt_done), 64'd1);

        // three-beat packet on queue 0; queue 1 untouched
        send_pkt(0, 2, 3, 8'h11, 8'h11);
        idle(2);
        check_vec("three_commit0", 64'(bus.commit_waddr[0 +: ADDR_W]), 64'd3);
        check_vec("three_commit1", 64'(bus.commit_waddr[ADDR_W +: ADDR_W]), 64'd1);
        idle(2);

        // overlong packet, then a packet reusing the rolled-back space
        do_reset();
        send_pkt(0, 1, 128, 0, 1);
        idle(2);
        check_vec("len_drop", 64'(bus.pkt_drop), 64'd1);
        check_vec("len_cause", 64'(bus.drop_cause), 64'd0);
        send_pkt(0, 4, 1, 8'h5A, 0);
        idle(1);
        check_vec("len_next_waddr", 64'(bus.ram_waddr), 64'd0);
        idle(3);

        // queue 0 fills against reader pointer 5
        do_reset();
        rdv[0] = 5;
        send_pkt(0, 3, 6, 8'h40, 1);
        idle(4);

        // sop abort on the third beat
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 0, 1, 8'h01);
        cycle(1'b0, 1'b0, 1'b0, 0, 1, 8'h02);
        cycle(1'b1, 1'b0, 1'b0, 0, 6, 8'h03);
        cycle(1'b0, 1'b0, 1'b0, 0, 6, 8'h04);
        check_vec("abort_waddr", 64'(bus.ram_waddr), 64'd0);
        cycle(1'b0, 1'b1, 1'b0, 0, 6, 8'h05);
        check_vec("abort_cause", 64'(bus.drop_cause), 64'd2);
        idle(3);

        // advance queue 0 to 1142, then wrap
        do_reset();
        for (int p = 0; p < 9; p++) begin
            rdv[0] = m_cmt[0];
            send_pkt(0, p, (p < 8) ? 127 : 126, p, 3);
        end
        idle(2);
        rdv[0] = m_cmt[0];
        send_pkt(0, 7, 3, 8'hC0, 1);
        idle(1);
        check_vec("wrap_waddr", 64'(bus.ram_waddr), 64'd0);
        idle(1);
        check_vec("wrap_commit0", 64'(bus.commit_waddr[0 +: ADDR_W]), 64'd1);

        // reset in the middle of a packet
        cycle(1'b1, 1'b0, 1'b0, 0, 2, 8'h77);
        cycle(1'b0, 1'b0, 1'b0, 0, 2, 8'h78);
        do_reset();
        idle(4);

        // random beats with a reader that moves now and then
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) begin
                for (int q = 0; q < NUM_Q; q++) begin
                    if ($urandom_range(0, 3) == 0) rdv[q] = (m_cmt[q] + int'($urandom_range(2, 20))) % RAM_DEPTH;
                    else                           rdv[q] = m_cmt[q];
                end
            end
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
                  int'($urandom_range(0, (1 << QSEL_W) - 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
